// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection: the light encoding driven by the
// traffic controller and read by the queue sensor, plus a small width helper.
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_OFF    = 2'b00,
        LIGHT_GREEN  = 2'b01,
        LIGHT_YELLOW = 2'b10,
        LIGHT_RED    = 2'b11
    } light_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lane_queue.sv
// ----------------------------------------------------------------------------
// lane_queue
// One street's vehicle queue: arrival counting, timed departures while the
// street is green, sticky overflow flag and the "traffic present" output.
//
// Build option: SENSOR_HOLD_EN adds a hold counter that keeps `present` high
// for HOLD_CYCLES cycles after the queue empties.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   arr      in   arrival pulse, one car per high cycle
//   light    in   this street's light (off is treated like red)
//   present  out  traffic present, driven from registered state only
//   count    out  queue count, saturates at 2^QW-1
//   ovf      out  sticky: an arrival was lost at saturation
// ----------------------------------------------------------------------------
module lane_queue
    import traffic_pkg::*;
#(
    parameter int QW            = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arr,
    input  light_t        light,
    output logic          present,
    output logic [QW-1:0] count,
    output logic          ovf
);

    localparam int             DTW     = cnt_width(DEPART_CYCLES - 1);
    localparam logic [DTW-1:0] DT_LAST = DTW'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0]  CNT_MAX = '1;

    if (DEPART_CYCLES < 1) begin : g_bad_depart
        $error("lane_queue: DEPART_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("lane_queue: HOLD_CYCLES must be >= 1");
    end

    logic [QW-1:0]  count_q, count_d;
    logic [DTW-1:0] dt_q, dt_d;
    logic           ovf_q, ovf_d;
    logic           nonzero;
    logic           advance;
    logic           depart;

    always_comb begin
        nonzero = (count_q != '0);
        advance = (light == LIGHT_GREEN) && nonzero;
        depart  = advance && (dt_q == DT_LAST);

        // Timer restarts from zero whenever it is not advancing, so any
        // interruption of green costs a full interval on the next green.
        dt_d = '0;
        if (advance && !depart) begin
            dt_d = dt_q + 1'b1;
        end

        count_d = count_q;
        ovf_d   = ovf_q;
        if (arr && !depart) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (!arr && depart) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dt_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dt_q    <= dt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SENSOR_HOLD_EN
    localparam int HW = cnt_width(HOLD_CYCLES);

    logic [HW-1:0] hc_q, hc_d;

    always_comb begin
        hc_d = hc_q;
        if (nonzero && (count_d == '0)) begin
            hc_d = HW'(HOLD_CYCLES);          // queue just emptied
        end else if (arr) begin
            hc_d = '0;                        // new car: the count takes over
        end else if (!nonzero && (hc_q != '0)) begin
            hc_d = hc_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
        end else begin
            hc_q <= hc_d;
        end
    end

    assign present = (count_q != '0) || (hc_q != '0);
`else
    assign present = (count_q != '0);
`endif

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/traffic_queue_sensor.sv
// ----------------------------------------------------------------------------
// traffic_queue_sensor
// Vehicle-detection side of the intersection: turns arrival pulses and the
// controller's light codes into the ta/tb traffic-present inputs. Two
// independent lane_queue instances, one per street; this level is wiring.
//
// Build option: SENSOR_HOLD_EN (post-empty hold on ta/tb, see lane_queue).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   arr_a, arr_b    arrival pulses per street
//   la, lb          light codes: 00 off, 01 green, 10 yellow, 11 red
//   ta, tb          traffic present per street
//   qa, qb          queue counts
//   ovf_a, ovf_b    sticky saturation-loss flags
// ----------------------------------------------------------------------------
module traffic_queue_sensor
    import traffic_pkg::*;
#(
    parameter int QW            = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic [1:0]    la,
    input  logic [1:0]    lb,
    output logic          ta,
    output logic          tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          ovf_a,
    output logic          ovf_b
);

    lane_queue #(
        .QW            (QW),
        .DEPART_CYCLES (DEPART_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .arr     (arr_a),
        .light   (light_t'(la)),
        .present (ta),
        .count   (qa),
        .ovf     (ovf_a)
    );

    lane_queue #(
        .QW            (QW),
        .DEPART_CYCLES (DEPART_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .arr     (arr_b),
        .light   (light_t'(lb)),
        .present (tb),
        .count   (qb),
        .ovf     (ovf_b)
    );

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// ----------------------------------------------------------------------------
// tb_traffic_queue_sensor
// Directed stimulus with hand-computed expectations (QW=4, DEPART_CYCLES=3,
// HOLD_CYCLES=2). The driver pushes the state expected after each edge into
// a scoreboard queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_traffic_queue_sensor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arr_a = 1'b0;
    logic       arr_b = 1'b0;
    logic [1:0] la = 2'b11;
    logic [1:0] lb = 2'b11;
    logic       ta, tb;
    logic [3:0] qa, qb;
    logic       ovf_a, ovf_b;

    traffic_queue_sensor #(
        .QW            (4),
        .DEPART_CYCLES (3),
        .HOLD_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .arr_a (arr_a),
        .arr_b (arr_b),
        .la    (la),
        .lb    (lb),
        .ta    (ta),
        .tb    (tb),
        .qa    (qa),
        .qb    (qb),
        .ovf_a (ovf_a),
        .ovf_b (ovf_b)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] OFF = 2'b00, GRN = 2'b01, YEL = 2'b10, RED = 2'b11;

    typedef struct {
        int    cyc;
        int    qa, qb, ta, tb, oa, ob;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string f, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)", nm, f, act, req, cyc);
        end
    endtask

    // Monitor: every cycle the DUT presents its state; compare it with the
    // expectation tagged for this cycle.
    exp_t cur;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc != cyc) begin
                chk(cur.nm, "cycle", cyc, cur.cyc);
            end else begin
                chk(cur.nm, "qa", int'(qa), cur.qa);
                chk(cur.nm, "qb", int'(qb), cur.qb);
                chk(cur.nm, "ta", int'(ta), cur.ta);
                chk(cur.nm, "tb", int'(tb), cur.tb);
                chk(cur.nm, "ovf_a", int'(ovf_a), cur.oa);
                chk(cur.nm, "ovf_b", int'(ovf_b), cur.ob);
                $display("txn cyc=%0d %s qa=%0d qb=%0d ta=%0d tb=%0d ovf_a=%0d ovf_b=%0d",
                         cyc, cur.nm, qa, qb, ta, tb, ovf_a, ovf_b);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic [1:0] al, input logic [1:0] bl,
                        input int eqa, input int eqb, input int eta, input int etb,
                        input int eoa, input int eob, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = r;
        arr_a = ra;
        arr_b = rb;
        la    = al;
        lb    = bl;
        e.cyc = cyc + 1;
        e.qa = eqa; e.qb = eqb; e.ta = eta; e.tb = etb; e.oa = eoa; e.ob = eob;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Lane A activity with lane B idle under red; ta follows qa!=0.
    task automatic stepa(input logic ra, input logic [1:0] al, input int eqa,
                         input int eoa, input string nm);
        step(1'b0, ra, 1'b0, al, RED, eqa, 0, (eqa != 0) ? 1 : 0, 0, eoa, 0, nm);
    endtask

    initial begin
        // Reset held with arrivals and green on both lanes.
        step(1'b1, 1'b1, 1'b1, GRN, GRN, 0, 0, 0, 0, 0, 0, "reset0");
        step(1'b1, 1'b1, 1'b1, GRN, GRN, 0, 0, 0, 0, 0, 0, "reset1");
        stepa(1'b0, RED, 0, 0, "reset_release");

`ifndef SENSOR_HOLD_EN
        // Accumulate under red.
        stepa(1'b1, RED, 1, 0, "acc1");
        stepa(1'b1, RED, 2, 0, "acc2");
        stepa(1'b1, RED, 3, 0, "acc3");
        for (int i = 0; i < 10; i++) stepa(1'b0, RED, 3, 0, "acc_hold");

        // Drain: one departure every third green cycle.
        begin
            int drain_q[9] = '{3, 3, 2, 2, 2, 1, 1, 1, 0};
            for (int i = 0; i < 9; i++) stepa(1'b0, GRN, drain_q[i], 0, "drain");
        end

        // Arrival coinciding with a departure.
        stepa(1'b1, RED, 1, 0, "sim_fill1");
        stepa(1'b1, RED, 2, 0, "sim_fill2");
        stepa(1'b0, GRN, 2, 0, "sim_t1");
        stepa(1'b0, GRN, 2, 0, "sim_t2");
        stepa(1'b1, GRN, 2, 0, "sim_both");
        stepa(1'b0, GRN, 2, 0, "sim_n1");
        stepa(1'b0, GRN, 2, 0, "sim_n2");
        stepa(1'b0, GRN, 1, 0, "sim_dep");
        stepa(1'b0, RED, 1, 0, "sim_stop");

        // Yellow and off block departures.
        for (int i = 0; i < 4; i++) stepa(1'b1, RED, 2 + i, 0, "blk_fill");
        for (int i = 0; i < 10; i++) stepa(1'b0, YEL, 5, 0, "blk_yellow");
        for (int i = 0; i < 10; i++) stepa(1'b0, OFF, 5, 0, "blk_off");
        // Interrupted green restarts the full interval.
        stepa(1'b0, GRN, 5, 0, "int_g1");
        stepa(1'b0, YEL, 5, 0, "int_y");
        stepa(1'b0, GRN, 5, 0, "int_r1");
        stepa(1'b0, GRN, 5, 0, "int_r2");
        stepa(1'b0, GRN, 4, 0, "int_r3");
        stepa(1'b0, RED, 4, 0, "int_stop");

        // Saturation from zero.
        step(1'b1, 1'b0, 1'b0, RED, RED, 0, 0, 0, 0, 0, 0, "sat_rst");
        for (int i = 1; i <= 15; i++) stepa(1'b1, RED, i, 0, "sat_fill");
        stepa(1'b1, RED, 15, 1, "sat_lost");
        stepa(1'b0, RED, 15, 1, "sat_hold");
        for (int k = 1; k <= 45; k++) stepa(1'b0, GRN, 15 - k / 3, 1, "sat_drain");
        for (int i = 0; i < 3; i++) stepa(1'b0, GRN, 0, 1, "sat_empty");
        step(1'b1, 1'b1, 1'b0, RED, RED, 0, 0, 0, 0, 0, 0, "sat_clear");

        // Lane B independence.
        step(1'b0, 1'b1, 1'b1, RED, RED, 1, 1, 1, 1, 0, 0, "b_both");
        step(1'b0, 1'b0, 1'b1, RED, RED, 1, 2, 1, 1, 0, 0, "b_arr2");
        step(1'b0, 1'b0, 1'b1, RED, RED, 1, 3, 1, 1, 0, 0, "b_arr3");
        begin
            int drain_b[9] = '{3, 3, 2, 2, 2, 1, 1, 1, 0};
            for (int i = 0; i < 9; i++)
                step(1'b0, 1'b0, 1'b0, RED, GRN, 1, drain_b[i], 1,
                     (drain_b[i] != 0) ? 1 : 0, 0, 0, "b_drain");
        end
`else
        // Post-empty hold: ta stays high two cycles after qa reaches zero.
        stepa(1'b1, RED, 1, 0, "hold_fill");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 1, 0, 1, 0, 0, 0, "hold_g1");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 1, 0, 1, 0, 0, 0, "hold_g2");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 0, 0, 1, 0, 0, 0, "hold_empty");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 0, 0, 1, 0, 0, 0, "hold_h1");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 0, 0, 0, 0, 0, 0, "hold_drop");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 0, 0, 0, 0, 0, 0, "hold_low");
        // Arrival during the hold keeps ta high.
        stepa(1'b1, RED, 1, 0, "rearm_fill");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 1, 0, 1, 0, 0, 0, "rearm_g1");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 1, 0, 1, 0, 0, 0, "rearm_g2");
        step(1'b0, 1'b0, 1'b0, GRN, RED, 0, 0, 1, 0, 0, 0, "rearm_empty");
        step(1'b0, 1'b1, 1'b0, GRN, RED, 1, 0, 1, 0, 0, 0, "rearm_arr");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, RED, RED, 1, 0, 1, 0, 0, 0, "rearm_keep");
`endif

        // Let the monitor consume the remaining expectations, bounded.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_scoreboard actual=%0d required=0 entries left", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_queue_sensor.md
Name: traffic_queue_sensor

Overview:
- Models the vehicle-detection side of the intersection.
- Consumes the light codes la/lb driven by the traffic controller and produces the ta/tb "traffic present" inputs that the controller samples.
- Keeps a per-street queue count. Arrival pulses increment it. While that street is green, one car departs every DEPART_CYCLES cycles.
- Used as the closed-loop environment and as the on-board sensor front-end.

Parameters:
- QW, 4: queue counter width; max count 2^QW-1.
- DEPART_CYCLES, 3: cycles of green per departing car; must be >= 1.
- HOLD_CYCLES, 2: post-empty hold time; used only when SENSOR_HOLD_EN is defined; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- arr_a  input  1  car-arrival pulse, street A (one car per high cycle)
- arr_b  input  1  car-arrival pulse, street B
- la  input  2  street A light: 00 off, 01 green, 10 yellow, 11 red
- lb  input  2  street B light, same encoding
- ta  output  1  traffic present on street A
- tb  output  1  traffic present on street B
- qa  output  QW  street A queue count
- qb  output  QW  street B queue count
- ovf_a  output  1  sticky: street A arrival lost at saturation
- ovf_b  output  1  sticky: street B arrival lost at saturation

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high, and overrides everything.
- Reset values: qa=qb=0, ta=tb=0, ovf_a=ovf_b=0, both departure timers=0, hold counters=0.
- Streets are fully independent. The rules below apply per lane, shown for A.
- Departure timer dt, range 0..DEPART_CYCLES-1:
  - Advances only when la==01 and qa!=0.
  - Cleared to 0 when la!=01 or qa==0.
  - When dt==DEPART_CYCLES-1 and it advances, a departure fires this cycle and dt returns to 0.
- Yellow (10), red (11) and off (00) all block departures. Off is treated as red.
- Count update at each rising edge:
  - arrival only: qa+1;
  - departure only: qa-1;
  - both: qa unchanged;
  - neither: hold.
- Saturation:
  - An arrival while qa==2^QW-1 with no departure leaves qa at max and sets ovf_a.
  - ovf_a stays set until rst.
- Underflow cannot occur, because departures require qa!=0.
- ta is a function of registered state only, with no combinational path from arr_a or la:
  - without SENSOR_HOLD_EN, ta = (qa!=0);
  - latency: arr_a high in cycle N gives qa and ta updated in cycle N+1.
- A light change mid-timer, green to yellow, clears dt. The next green restarts a full DEPART_CYCLES interval.
- rst asserted mid-operation clears counts and flags on the next edge, regardless of concurrent arrivals.

Optional Feature:
- Macro: SENSOR_HOLD_EN.
- Defined: a per-lane hold counter hc provides hysteresis.
  - On the edge where qa goes from nonzero to 0, hc loads HOLD_CYCLES.
  - While qa==0 and hc!=0, hc decrements each cycle.
  - ta = (qa!=0) || (hc!=0).
  - An arrival while holding clears hc; ta stays high continuously.
  - rst clears hc.
  - Result: ta stays high for exactly HOLD_CYCLES extra cycles after the queue empties, so the controller is not dropped out of green by a one-cycle gap.
- Not defined: no hc logic and HOLD_CYCLES is unused; ta = (qa!=0).

Decomposition:
- Shared package traffic_pkg:
  - light_t enum, logic [1:0]: LIGHT_OFF=00, LIGHT_GREEN=01, LIGHT_YELLOW=10, LIGHT_RED=11.
  - Used by both the controller and this block.
- Sub-module lane_queue, instantiated twice (A and B):
  - Parameters: QW, DEPART_CYCLES, HOLD_CYCLES.
  - Ports: clk, rst, arr, light, present, count, ovf.
  - Contains the departure timer, counter, overflow flag and optional hold counter.
- Top level: wiring only.

Test Plan (QW=4, DEPART_CYCLES=3, SENSOR_HOLD_EN undefined unless stated):
- Reset: rst high 2 cycles with arr_a=arr_b=1 and la=lb=01 -> qa=qb=0, ta=tb=0, ovf_a=ovf_b=0 while rst high and on the first cycle after release.
- Accumulate: la=11, three consecutive arr_a pulses -> ta=1 one cycle after the first pulse; qa=1,2,3; qa stays 3 for 10 further red cycles; tb=0 throughout.
- Drain: qa=3, la switched to 01 -> qa=2 after 3 cycles, 1 after 6, 0 after 9; ta falls in the same cycle qa reaches 0.
- Simultaneous: la=01 with qa=2, and arr_a pulsed exactly on a departure cycle -> qa stays 2; the next departure occurs 3 cycles later.
- Blocking and saturation:
  - la=10 or la=00 with qa=5 for 20 cycles -> qa stays 5.
  - Returning to green after 1 cycle of timer progress -> the first departure needs a full 3 cycles.
  - 16 arrivals from 0 under red -> qa=15, ovf_a=1, and ovf_a remains 1 after draining to 0 until rst.
- Hold (SENSOR_HOLD_EN, HOLD_CYCLES=2):
  - qa drains 1 to 0 -> ta stays high exactly 2 cycles after qa==0, then 0.
  - Repeat with arr_a pulsed during the hold -> ta never deasserts and qa=1.
